// File: rtl/cp0_pkg.sv
// Shared CP0 constants: ExcCodes, register addresses ({reg, sel}), exc_flags bit indices.
package cp0_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;

  localparam int unsigned FLAG_ADEL_IF = 6;
  localparam int unsigned FLAG_RI      = 5;
  localparam int unsigned FLAG_OV      = 4;
  localparam int unsigned FLAG_SYS     = 3;
  localparam int unsigned FLAG_BP      = 2;
  localparam int unsigned FLAG_ADEL_D  = 1;
  localparam int unsigned FLAG_ADES    = 0;

  // Fixed-priority ExcCode select; only meaningful when some event is present.
  function automatic logic [4:0] exc_code(input logic int_pend, input logic [6:0] flags);
    if (int_pend)                   return EXC_INT;
    else if (flags[FLAG_ADEL_IF])   return EXC_ADEL;
    else if (flags[FLAG_RI])        return EXC_RI;
    else if (flags[FLAG_OV])        return EXC_OV;
    else if (flags[FLAG_SYS])       return EXC_SYS;
    else if (flags[FLAG_BP])        return EXC_BP;
    else if (flags[FLAG_ADEL_D])    return EXC_ADEL;
    else                            return EXC_ADES;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with TI flag; Count advances once every COUNT_DIV cycles.
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_count,
  input  logic        i_wr_compare,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  localparam int unsigned DivW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [DivW-1:0] r_div, w_div_d;
  logic [31:0]     r_count, w_count_d, r_compare;
  logic            r_ti;

  always_comb begin
    w_count_d = r_count;
    w_div_d   = r_div + 1'b1;
    if (i_wr_count) begin
      w_count_d = i_wdata;
      w_div_d   = '0;
    end else if (r_div == DivW'(COUNT_DIV - 1)) begin
      w_count_d = r_count + 32'd1;
      w_div_d   = '0;
    end
  end

  // Compare write clears TI and wins over a match in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_div     <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_div   <= w_div_d;
      if (i_wr_compare) begin
        r_compare <= i_wdata;
        r_ti      <= 1'b0;
      end else if (w_count_d == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_unit.sv
// MIPS-style CP0: Status/Cause/EPC/BadVAddr, exception and eret redirect at WB.
// Timer (Count/Compare/TI) present only when CP0_TIMER_EN is defined.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int unsigned HW_INT_NUM     = 6,
  parameter int unsigned COUNT_DIV      = 2,
  parameter logic [31:0] EXC_ENTER_ADDR = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic                  mtc0,
  input  logic                  mfc0,
  input  logic                  eret,
  input  logic [7:0]            cp0_addr,
  input  logic [31:0]           cp0_wdata,
  input  logic [6:0]            exc_flags,
  input  logic [31:0]           pc,
  input  logic [31:0]           badvaddr_in,
  input  logic                  is_ds,
  input  logic [HW_INT_NUM-1:0] hw_int,
  output logic [31:0]           cp0_rdata,
  output logic                  exc_valid,
  output logic [31:0]           exc_pc,
  output logic                  rf_kill,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  logic [7:0]  r_im;
  logic        r_exl, r_ie, r_bd;
  logic [4:0]  r_exccode;
  logic [1:0]  r_ip_sw;
  logic [5:0]  r_ip_hw;
  logic [31:0] r_epc, r_badvaddr;

  logic [5:0]  w_hw_ext;
  logic [7:0]  w_ip;
  logic [31:0] w_count, w_compare;
  logic        w_ti, w_int_pend, w_exc_take, w_eret_take, w_wr;
  logic [4:0]  w_code;
  logic        w_unused_mfc0;

  // mfc0 needs no qualification: the read mux is always live.
  assign w_unused_mfc0 = mfc0;

  always_comb begin
    w_hw_ext                   = '0;
    w_hw_ext[HW_INT_NUM-1:0]   = hw_int;
  end

`ifdef CP0_TIMER_EN
  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_wr_count   (w_wr && (cp0_addr == ADDR_COUNT)),
    .i_wr_compare (w_wr && (cp0_addr == ADDR_COMPARE)),
    .i_wdata      (cp0_wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );
`else
  logic [4:0] w_unused_div;
  assign w_unused_div = 5'(COUNT_DIV);
  assign w_count      = '0;
  assign w_compare    = '0;
  assign w_ti         = 1'b0;
`endif

  // IP7 is shared by the timer and the sixth hardware line.
  assign w_ip        = {w_ti | r_ip_hw[5], r_ip_hw[4:0], r_ip_sw};
  assign w_int_pend  = r_ie & ~r_exl & (|(w_ip & r_im));
  assign w_exc_take  = ~reset & wb_valid & (w_int_pend | (|exc_flags));
  assign w_eret_take = ~reset & wb_valid & eret & ~w_exc_take;
  assign w_wr        = wb_valid & mtc0 & ~w_exc_take;
  assign w_code      = exc_code(w_int_pend, exc_flags);

  assign exc_valid = w_exc_take | w_eret_take;
  assign rf_kill   = w_exc_take;
  assign exc_pc    = w_exc_take ? EXC_ENTER_ADDR : r_epc;

  assign status_o = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign cause_o  = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};
  assign epc_o    = r_epc;

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      ADDR_BADVADDR: cp0_rdata = r_badvaddr;
      ADDR_COUNT:    cp0_rdata = w_count;
      ADDR_COMPARE:  cp0_rdata = w_compare;
      ADDR_STATUS:   cp0_rdata = status_o;
      ADDR_CAUSE:    cp0_rdata = cause_o;
      ADDR_EPC:      cp0_rdata = r_epc;
      default:       cp0_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_exccode  <= '0;
      r_ip_sw    <= '0;
      r_ip_hw    <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else begin
      r_ip_hw <= w_hw_ext;
      if (w_exc_take) begin
        r_exl     <= 1'b1;
        r_exccode <= w_code;
        // Nested exceptions keep the original return point.
        if (!r_exl) begin
          r_epc <= is_ds ? (pc - 32'd4) : pc;
          r_bd  <= is_ds;
        end
        if ((w_code == EXC_ADEL) || (w_code == EXC_ADES)) begin
          r_badvaddr <= exc_flags[FLAG_ADEL_IF] ? pc : badvaddr_in;
        end
      end else begin
        if (w_eret_take) r_exl <= 1'b0;
        if (w_wr) begin
          case (cp0_addr)
            ADDR_STATUS: begin
              r_im  <= cp0_wdata[15:8];
              r_exl <= cp0_wdata[1];
              r_ie  <= cp0_wdata[0];
            end
            ADDR_CAUSE: r_ip_sw <= cp0_wdata[9:8];
            ADDR_EPC:   r_epc   <= cp0_wdata;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL take parameter HW_INT_NUM, default 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+i].
REQ-002 SHALL take parameter COUNT_DIV, default 2, clock cycles per Count increment (1..16).
REQ-003 SHALL take parameter EXC_ENTER_ADDR, default 32'hBFC00380, exception vector.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- wb_valid  in  1  WB-stage instruction valid this cycle.
- mtc0 / mfc0 / eret  in  1 each  instruction type.
- cp0_addr  in  8  {reg[4:0], sel[2:0]}.
- cp0_wdata  in  32  MTC0 data.
- exc_flags  in  7  {adel_if, ri, ov, sys, bp, adel_d, ades}.
- pc / badvaddr_in  in  32 each  instruction PC / data address.
- is_ds  in  1  instruction is in a delay slot.
- hw_int  in  HW_INT_NUM  level interrupt requests.
- cp0_rdata  out  32  MFC0 read data.
- exc_valid  out  1  flush pipeline and redirect.
- exc_pc  out  32  redirect target.
- rf_kill  out  1  suppress the regfile and HI/LO write this cycle.
- status_o / cause_o / epc_o  out  32 each  register views.

Function
REQ-006 SHALL implement BadVAddr(8,0) RO, Count(9,0), Compare(11,0), Status(12,0), Cause(13,0), EPC(14,0); other addresses read 0, and writes to them are ignored.
REQ-007 SHALL drive cp0_rdata combinationally from current register state (pre-update values).
REQ-008 SHALL make Status writable only in bits IM[15:8], EXL[1], IE[0]; BEV[22] reads as constant 1; all other bits read 0.
REQ-009 SHALL make Cause writable only in IP[9:8]; IP[2+i] SHALL be hw_int[i] registered one cycle; IP[15] SHALL equal TI[30]; BD[31] and ExcCode[6:2] are read-only.
REQ-010 SHALL compute int_pend = IE & ~EXL & |(Cause[15:8] & Status[15:8]).
REQ-011 SHALL take an event only in a cycle with wb_valid=1, using fixed priority: interrupt > adel_if > ri > ov > sys > bp > adel_d > ades.
REQ-012 SHALL use ExcCode Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=0xA, Ov=0xC.
REQ-013 On a taken exception or interrupt, SHALL set at the clock edge:
- EXL<=1 and ExcCode.
- Only if EXL was 0: EPC<=is_ds ? pc-4 : pc and BD<=is_ds.
- BadVAddr<=pc for adel_if, badvaddr_in for adel_d/ades.
REQ-014 On a taken event, SHALL assert exc_valid=1, rf_kill=1 and exc_pc=EXC_ENTER_ADDR in the same cycle (0-cycle latency).
REQ-015 On eret with wb_valid and no exception, SHALL assert exc_valid=1 and exc_pc=EPC, clear EXL at the edge, and hold rf_kill=0.
REQ-016 SHALL ignore mtc0 in a cycle where an event is taken; otherwise SHALL perform the write at the edge when wb_valid=1.
REQ-017 SHALL increment Count (mod 2^32) once every COUNT_DIV cycles; an mtc0 Count SHALL load cp0_wdata and restart the divider at 0.
REQ-018 SHALL set TI when the post-update Count equals Compare; an mtc0 Compare SHALL clear TI and win over a same-cycle match.
REQ-019 With wb_valid=0, SHALL keep exc_valid=0 and rf_kill=0, and SHALL change no architectural state except Count, TI and the sampled IP bits.

Reset
REQ-020 SHALL reset to: Status=0x00400000, Cause=0, Count=0, Compare=0, EPC=0, BadVAddr=0, divider=0, exc_valid=0.
REQ-021 Reset asserted mid-operation SHALL override any same-cycle event, mtc0 or eret.

Configuration
REQ-022 Macro CP0_TIMER_EN SHALL be used.
- Defined: Count, Compare and TI per REQ-017/018.
- Undefined: Count and Compare read 0, their writes are ignored, TI=0, and no divider logic is synthesized.

Structure
REQ-023 SHALL place ExcCode constants, CP0 register address constants and exc_flags bit indices in shared package cp0_pkg.
REQ-024 SHALL implement the Count/Compare/TI logic in sub-module cp0_timer, instantiated only under CP0_TIMER_EN.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- sys=1 and wb_valid=1, pc=0xBFC00100, is_ds=0 -> exc_valid=1, exc_pc=0xBFC00380, rf_kill=1; next cycle EPC=0xBFC00100, ExcCode=8, EXL=1.
- ov=1 and bp=1 together, is_ds=1, pc=0x80000010 -> ExcCode=0xC, EPC=0x8000000C, BD=1.
- EXL=1, then ri -> ExcCode=0xA, EPC unchanged; then eret -> exc_pc=old EPC, EXL=0.
- Status=0x00008001 and Compare=5 (COUNT_DIV=2) -> TI set about 10 cycles after reset; next wb_valid -> interrupt with ExcCode=0; mtc0 Compare clears TI.
- hw_int[0]=1 with Status=0x00000401 -> interrupt on the second wb_valid cycle after assertion; with IM2=0 -> no interrupt.
- mtc0 Status together with adel_d (badvaddr_in=0x1003) -> write dropped, BadVAddr=0x1003, ExcCode=4.
